// File: rtl/wave_generator.sv
// wave_generator: tick-driven waveform source (saw up, saw down, triangle,
// square) with a glitch-free mode switch and a registered sample bus.
// Each accepted tick (tick & en) advances the phase and emits one sample.
// The sample appears the cycle after the tick, together with sampleValid.
// wrapPulse marks the step that completes a waveform period.
// A waveform request is adopted only at a period wrap, or at once while en is low.
// Optional build macro WAVE_AMPLITUDE_SCALE_EN adds input ampShift[1:0].
// With it, each new sample is shifted right by that amount.
module wave_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic [2:0]       waveSel,
`ifdef WAVE_AMPLITUDE_SCALE_EN
  input  logic [1:0]       ampShift,
`endif
  output logic [WIDTH-1:0] sample,
  output logic             sampleValid,
  output logic             wrapPulse
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  localparam logic [2:0] SEL_SAW_UP   = 3'b000;
  localparam logic [2:0] SEL_SAW_DOWN = 3'b001;
  localparam logic [2:0] SEL_TRIANGLE = 3'b010;
  localparam logic [2:0] SEL_SQUARE   = 3'b011;

  // Triangle direction FSM; stays UP in every other mode.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [WIDTH-1:0] phase, next_phase;
  logic             dir, next_dir;
  logic [2:0]       sel_active, next_sel;
  logic             step;
  logic             wrap;
  logic [1:0]       shift;
  logic [WIDTH-1:0] next_sample;

  assign step = tick & en;

`ifdef WAVE_AMPLITUDE_SCALE_EN
  assign shift = ampShift;
`else
  assign shift = 2'd0;
`endif

  // Map a mode and phase to the unscaled output value.
  function automatic logic [WIDTH-1:0] wave_map(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] ph);
    case (sel)
      SEL_SAW_UP:   wave_map = ph;
      SEL_SAW_DOWN: wave_map = ~ph;
      SEL_TRIANGLE: wave_map = ph;
      SEL_SQUARE:   wave_map = ph[WIDTH-1] ? MAX : ZERO;
      default:      wave_map = ZERO;
    endcase
  endfunction

  // Next phase, direction, wrap flag and selection for this cycle.
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    next_phase = phase;
    next_dir   = dir;
    next_sel   = sel_active;
    wrap       = 1'b0;

    if (step) begin
      if (sel_active == SEL_TRIANGLE) begin
        if (dir == DIR_UP) begin
          next_phase = phase + 1'b1;
          if (next_phase == MAX) next_dir = DIR_DOWN;
        end else begin
          next_phase = phase - 1'b1;
          if (next_phase == ZERO) begin
            next_dir = DIR_UP;
            wrap     = 1'b1;
          end
        end
      end else begin
        next_phase = phase + 1'b1;
        wrap       = (phase == MAX);
      end
    end

    // A pending request is adopted while idle or exactly at a period wrap.
    // The new mode always starts from phase 0 and dir UP.
    if ((!en || wrap) && (waveSel != sel_active)) begin
      next_sel   = waveSel;
      next_phase = ZERO;
      next_dir   = DIR_UP;
    end

    next_sample = wave_map(next_sel, next_phase) >> shift;
  end

  // State and output registers; rst overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before this edge.
    if (rst) begin
      phase       <= ZERO;
      dir         <= DIR_UP;
      sel_active  <= SEL_SAW_UP;
      sample      <= ZERO;
      sampleValid <= 1'b0;
      wrapPulse   <= 1'b0;
    end else begin
      phase       <= next_phase;
      dir         <= next_dir;
      sel_active  <= next_sel;
      sampleValid <= step;
      wrapPulse   <= wrap;
      if (step) sample <= next_sample;
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// tb_wave_generator: directed plus random checks of wave_generator.
// The reference model tracks each mode as a position within its period and
// derives phase and sample from that position with plain arithmetic.
module tb_wave_generator;

  localparam int W       = 8;
  localparam int MAXV    = (1 << W) - 1;
  localparam int HALF    = 1 << (W - 1);
  localparam int PERIOD  = 1 << W;

  logic         clk = 1'b0;
  logic         rst, tick, en;
  logic [2:0]   waveSel;
  logic [1:0]   amp;
  logic [W-1:0] sample;
  logic         sampleValid, wrapPulse;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: active mode, position within the period, registered outputs.
  int m_mode, m_pos, m_sample;
  logic m_valid, m_wrap;
  int wrap_count;

  always #5 clk = ~clk;

  wave_generator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .waveSel    (waveSel),
`ifdef WAVE_AMPLITUDE_SCALE_EN
    .ampShift   (amp),
`endif
    .sample     (sample),
    .sampleValid(sampleValid),
    .wrapPulse  (wrapPulse)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int period_of(input int mode);
    return (mode == 2) ? 2 * MAXV : PERIOD;
  endfunction

  function automatic int phase_of(input int mode, input int pos);
    if (mode == 2) return (pos <= MAXV) ? pos : 2 * MAXV - pos;
    return pos;
  endfunction

  function automatic int wave_val(input int mode, input int ph);
    case (mode)
      0:       return ph;
      1:       return MAXV - ph;
      2:       return ph;
      3:       return (ph >= HALF) ? MAXV : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic t, input logic e,
                            input int s, input int a);
    logic stp;
    int   sh;
    stp = t & e;
`ifdef WAVE_AMPLITUDE_SCALE_EN
    sh = a;
`else
    sh = 0;
`endif
    if (r) begin
      m_mode = 0; m_pos = 0; m_sample = 0; m_valid = 0; m_wrap = 0;
    end else begin
      m_valid = stp;
      m_wrap  = 0;
      if (stp) begin
        m_pos  = (m_pos + 1) % period_of(m_mode);
        m_wrap = (m_pos == 0);
      end
      if ((!e || m_wrap) && s != m_mode) begin
        m_mode = s;
        m_pos  = 0;
      end
      if (stp) m_sample = wave_val(m_mode, phase_of(m_mode, m_pos)) >> sh;
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic e,
                     input int s, input int a);
    @(negedge clk);
    rst = r; tick = t; en = e; waveSel = 3'(s); amp = 2'(a);
    model_step(r, t, e, s, a);
    @(posedge clk);
    #1;
    check_eq("model_sample", 32'(sample), 32'(m_sample));
    check_eq("model_valid", 32'(sampleValid), 32'(m_valid));
    check_eq("model_wrap", 32'(wrapPulse), 32'(m_wrap));
    if (wrapPulse === 1'b1) wrap_count++;
  endtask

  initial begin
    int s_rand;
    rst = 1'b1; tick = 1'b0; en = 1'b0; waveSel = 3'd0; amp = 2'd0;
    m_mode = 0; m_pos = 0; m_sample = 0; m_valid = 0; m_wrap = 0;

    // Reset, including a tick presented during reset.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check_eq("reset_sample", 32'(sample), 0);
    check_eq("reset_valid", 32'(sampleValid), 0);
    check_eq("reset_wrap", 32'(wrapPulse), 0);

    // Sawtooth up, ticks spaced three cycles apart.
    wrap_count = 0;
    for (int i = 1; i <= 256; i++) begin
      cyc(0, 1, 1, 0, 0);
      check_eq("saw_sample", 32'(sample), 32'(i % 256));
      check_eq("saw_valid", 32'(sampleValid), 1);
      check_eq("saw_wrap", 32'(wrapPulse), (i == 256) ? 1 : 0);
      cyc(0, 0, 1, 0, 0);
      check_eq("saw_gap_valid", 32'(sampleValid), 0);
      cyc(0, 0, 1, 0, 0);
    end
    check_eq("saw_wrap_count", 32'(wrap_count), 1);

    // Triangle, adopted while idle, back-to-back ticks.
    cyc(0, 0, 0, 2, 0);
    wrap_count = 0;
    for (int i = 1; i <= 510; i++) begin
      cyc(0, 1, 1, 2, 0);
      check_eq("tri_sample", 32'(sample), (i <= 255) ? i : 510 - i);
    end
    check_eq("tri_wrap_last", 32'(wrapPulse), 1);
    check_eq("tri_wrap_count", 32'(wrap_count), 1);

    // Square.
    cyc(0, 0, 0, 3, 0);
    for (int i = 1; i <= 256; i++) begin
      cyc(0, 1, 1, 3, 0);
      check_eq("sq_sample", 32'(sample), ((i % 256) >= 128) ? 255 : 0);
    end

    // Glitch-free switch: saw down is requested at phase 100 and waits for the wrap.
    cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= 100; i++) cyc(0, 1, 1, 0, 0);
    check_eq("sw_at100", 32'(sample), 100);
    for (int i = 101; i <= 255; i++) begin
      cyc(0, 1, 1, 1, 0);
      check_eq("sw_pending", 32'(sample), i);
    end
    cyc(0, 1, 1, 1, 0);
    check_eq("sw_wrap_sample", 32'(sample), 255);
    check_eq("sw_wrap_pulse", 32'(wrapPulse), 1);
    cyc(0, 1, 1, 1, 0);
    check_eq("sw_down_next", 32'(sample), 254);

    // Ticks with en low are ignored.
    wrap_count = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 1, 0);
      check_eq("en0_valid", 32'(sampleValid), 0);
      check_eq("en0_sample", 32'(sample), 254);
    end
    check_eq("en0_wraps", 32'(wrap_count), 0);
    cyc(0, 0, 0, 2, 0);
    cyc(0, 1, 1, 2, 0);
    check_eq("en0_tri_first", 32'(sample), 1);

    // Reset in the middle of a triangle, while the phase is falling.
    for (int i = 0; i < 469; i++) cyc(0, 1, 1, 2, 0);
    check_eq("tri_down40", 32'(sample), 40);
    cyc(1, 1, 1, 2, 0);
    check_eq("rst_mid_sample", 32'(sample), 0);
    check_eq("rst_mid_valid", 32'(sampleValid), 0);
    cyc(0, 1, 1, 2, 0);
    check_eq("rst_mid_next", 32'(sample), 1);
    cyc(0, 1, 1, 2, 0);
    check_eq("rst_mid_saw", 32'(sample), 2);

    // Random traffic against the model.
    s_rand = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) s_rand = $urandom_range(0, 7);
      cyc(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) != 0), s_rand, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
- Downstream consumer of the frequency divider's one-cycle tick (its outSignal).
- Each accepted tick advances an internal phase and emits one registered sample of the selected waveform: sawtooth up, sawtooth down, triangle or square.
- The sample bus feeds the DAC/PWM output stage.
- Waveform selection is glitch-free: a new selection takes effect only at a period boundary or while idle.

Parameters:
- WIDTH, 8, bit width of phase counter and sample output; full scale MAX = 2^WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle step strobe from the frequency divider
- en  input  1  generator enable; ticks are ignored while low
- waveSel  input  3  requested waveform: 000 saw up, 001 saw down, 010 triangle, 011 square, others are silent
- sample  output  WIDTH  registered waveform sample
- sampleValid  output  1  one-cycle pulse, high in the cycle sample holds a new value
- wrapPulse  output  1  one-cycle pulse marking the end of a waveform period

Behaviour:
- Interface (already decided): one clock, clk; rst is synchronous and active-high; rst has priority over every other input.
- Reset values:
  - phase=0, dir=UP, selActive=000.
  - sample=0, sampleValid=0, wrapPulse=0.
- Step condition: step = tick & en, sampled on a clk edge.
  - The new sample is visible the cycle after tick, together with sampleValid=1.
  - No step means sample holds and sampleValid=0.
- Phase, modes 000/001/011/silent: phase <= phase+1 mod 2^WIDTH on each step.
  - wrapPulse=1 on the step where phase goes MAX->0.
- Phase, triangle mode (010), direction FSM:
  - UP: phase+1 on each step. The step reaching MAX moves to DOWN.
  - DOWN: phase-1 on each step. The step reaching 0 moves to UP and sets wrapPulse=1.
  - No repeated endpoint samples; period = 2*MAX steps.
- Sample mapping, applied to the post-step phase:
  - saw up: phase
  - saw down: ~phase
  - triangle: phase
  - square: MAX when phase[WIDTH-1]=1, else 0
  - silent codes: 0 (phase still runs)
- Selection latch:
  - selActive loads waveSel when en=0 (any cycle), or on a wrapping step.
  - When selActive changes: phase=0, dir=UP, and that cycle's sample is computed from the new mode at phase 0.
  - A waveSel change mid-period with en=1 is held pending until the wrap.
- Boundary cases:
  - tick during rst: ignored.
  - tick with en=0: ignored, no outputs pulse.
  - en falling mid-period: phase and sample freeze. If waveSel differs, the new mode is adopted immediately with phase reset.
  - Back-to-back ticks (divider value 0): one step per cycle, no loss.
  - Reset mid-period: all state returns to reset values on that edge.
- Width rules: all phase arithmetic is modulo 2^WIDTH, unsigned; no saturation except at the triangle turnarounds.

Optional Feature:
- Macro: WAVE_AMPLITUDE_SCALE_EN.
- When defined:
  - Adds input ampShift[1:0].
  - sample = mapped value >> ampShift (logical shift, 0..3).
  - ampShift is sampled at the step, so a change appears with the next new sample.
- When undefined:
  - The port is absent and the output is always full scale.

Test Plan:
- Sawtooth, WIDTH=8: rst, waveSel=000, en=1, 256 ticks spaced 3 cycles -> sample 1,2,…,255,0; wrapPulse on the 256th tick only; sampleValid once per tick, one cycle after tick.
- Triangle: waveSel=010, 510 ticks -> sample 1..255 then 254..0; wrapPulse once, at the return to 0; dir flips exactly at 255.
- Square: waveSel=011, 256 ticks -> sample 0 for ticks 1–127, 255 for ticks 128–255, 0 at tick 256.
- Glitch-free switch: saw up at phase 100, set waveSel=001 with en=1 -> saw up continues to 255 then wraps; the next sample comes from saw down starting at phase 0 (sample=255 at phase 0, then 254…).
- en/tick interplay: en=0 with 10 ticks -> sample frozen, no pulses. While en=0, change waveSel to 010 -> phase=0, dir=UP. Then en=1 plus one tick -> sample=1.
- Reset mid-triangle (DOWN, phase 40): assert rst together with tick -> sample=0, dir=UP, selActive=000, no sampleValid; the next tick gives sample=1.
